pixel_histogram: RTL and testbench

PIXEL_HISTOGRAM -- requirements
Module: pixel_histogram

---
 rtl/pixel_histogram.sv | 156 +++++++++++++++
 tb/tb_pixel_histogram.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_histogram.sv
// pixel_histogram
//   Builds a 2^BIN_BITS-bin histogram of a dual-pixel (2 x 10-bit) stream
//   over one frame, then streams the bins out over a valid/ready port and
//   clears each bin as it is read.
//
// Ports
//   clk_pixel_i   pixel clock (sole clock)
//   reset_n_i     asynchronous active-low reset
//   pd_i          pixel data: pixel0 = [9:0], pixel1 = [19:10]
//   fv_i / lv_i   frame valid / line valid
//   enable_i      arm capture; sampled only at frame start
//   hist_valid_o  readout beat valid
//   hist_ready_i  readout sink ready
//   hist_bin_o    bin index of the current beat
//   hist_data_o   bin count of the current beat
//   hist_last_o   beat for the final bin
//   frame_cnt_o   number of completed histogram dumps (wraps at 16 bits)
//   drop_o        one-cycle pulse when a frame start is skipped
module pixel_histogram #(
    parameter int BIN_BITS = 6,
    parameter int CNT_W    = 24
) (
    input  logic                clk_pixel_i,
    input  logic                reset_n_i,
    input  logic [19:0]         pd_i,
    input  logic                fv_i,
    input  logic                lv_i,
    input  logic                enable_i,
    output logic                hist_valid_o,
    input  logic                hist_ready_i,
    output logic [BIN_BITS-1:0] hist_bin_o,
    output logic [CNT_W-1:0]    hist_data_o,
    output logic                hist_last_o,
    output logic [15:0]         frame_cnt_o,
    output logic                drop_o
);

    localparam int NBINS = 1 << BIN_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DUMP
    } state_t;

    state_t              state_q, state_d;
    logic                fv_q;
    logic                frame_start, frame_end;
    logic                sample;
    logic                wr_q;
    logic [BIN_BITS-1:0] bin0_q, bin1_q;
    logic [BIN_BITS-1:0] idx_q;
    logic                idx_last;
    logic                xfer;
    logic                drop_d, drop_q;
    logic [15:0]         frame_cnt_q;
    logic [CNT_W-1:0]    bins_q [NBINS];
    logic [1:0]          inc    [NBINS];

    // Saturating add of a 0..2 increment; the carry out flags overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0]       d);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + (CNT_W+1)'(d);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    assign frame_start = fv_i & ~fv_q;
    assign frame_end   = ~fv_i & fv_q;
    // fv_i=1 is required, so the frame-end cycle is never counted.
    assign sample      = (state_q == ACCUM) & fv_i & lv_i;
    assign idx_last    = (idx_q == '1);
    assign xfer        = (state_q == DUMP) & hist_ready_i;

    always_comb begin
        state_d = state_q;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start && enable_i) state_d = ACCUM;
            end
            ACCUM: begin
                // A frame start here means fv dipped for one cycle: close
                // the current frame and skip the new one.
                if (frame_end || frame_start) state_d = DUMP;
                drop_d = frame_start;
            end
            DUMP: begin
                drop_d = frame_start;
                if (xfer && idx_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            fv_q        <= 1'b0;
            wr_q        <= 1'b0;
            bin0_q      <= '0;
            bin1_q      <= '0;
            idx_q       <= '0;
            drop_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fv_q    <= fv_i;
            drop_q  <= drop_d;
            wr_q    <= sample;
            if (sample) begin
                bin0_q <= pd_i[9 -: BIN_BITS];
                bin1_q <= pd_i[19 -: BIN_BITS];
            end
            if (state_q != DUMP) begin
                idx_q <= '0;
            end else if (xfer) begin
                idx_q <= idx_q + 1'b1;
            end
            if (xfer && idx_last) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Per-bin increment: a bin hit by both pixels naturally receives 2.
    always_comb begin
        for (int unsigned i = 0; i < NBINS; i++) begin
            inc[i] = '0;
            if (wr_q) begin
                inc[i] = {1'b0, (bin0_q == BIN_BITS'(i))} +
                         {1'b0, (bin1_q == BIN_BITS'(i))};
            end
        end
    end

    always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < NBINS; i++) bins_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NBINS; i++) begin
                if (xfer && (idx_q == BIN_BITS'(i))) begin
                    bins_q[i] <= '0;
                end else if (inc[i] != 2'd0) begin
                    bins_q[i] <= sat_add(bins_q[i], inc[i]);
                end
            end
        end
    end

    assign hist_valid_o = (state_q == DUMP);
    assign hist_bin_o   = idx_q;
    assign hist_data_o  = (state_q == DUMP) ? bins_q[idx_q] : '0;
    assign hist_last_o  = (state_q == DUMP) & idx_last;
    assign frame_cnt_o  = frame_cnt_q;
    assign drop_o       = drop_q;

endmodule

// File: tb/tb_pixel_histogram.sv
// Scoreboard bench for pixel_histogram. Two instances share the stimulus:
// the default configuration and a CNT_W=4 copy used for saturation.
module tb_pixel_histogram;

    logic        clk;
    logic        rst_n;
    logic [19:0] pd;
    logic        fv, lv, enable, ready;

    logic        hist_valid, hist_last, drop;
    logic [5:0]  hist_bin;
    logic [23:0] hist_data;
    logic [15:0] frame_cnt;

    logic        s_valid, s_last, s_drop;
    logic [5:0]  s_bin;
    logic [3:0]  s_data;
    logic [15:0] s_fc;

    pixel_histogram #(.BIN_BITS(6), .CNT_W(24)) u_dut (
        .clk_pixel_i (clk),        .reset_n_i   (rst_n),
        .pd_i        (pd),         .fv_i        (fv),
        .lv_i        (lv),         .enable_i    (enable),
        .hist_valid_o(hist_valid), .hist_ready_i(ready),
        .hist_bin_o  (hist_bin),   .hist_data_o (hist_data),
        .hist_last_o (hist_last),  .frame_cnt_o (frame_cnt),
        .drop_o      (drop)
    );

    pixel_histogram #(.BIN_BITS(6), .CNT_W(4)) u_sat (
        .clk_pixel_i (clk),        .reset_n_i   (rst_n),
        .pd_i        (pd),         .fv_i        (fv),
        .lv_i        (lv),         .enable_i    (enable),
        .hist_valid_o(s_valid),    .hist_ready_i(ready),
        .hist_bin_o  (s_bin),      .hist_data_o (s_data),
        .hist_last_o (s_last),     .frame_cnt_o (s_fc),
        .drop_o      (s_drop)
    );

    typedef struct packed {
        logic [5:0]  bin;
        logic [23:0] data;
        logic        last;
        logic [3:0]  sat;
    } beat_t;

    beat_t q[$];
    int    exp_cnt [64];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    drop_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < 64; i++) begin
            beat_t b;
            b.bin  = 6'(i);
            b.data = 24'(exp_cnt[i]);
            b.last = (i == 63);
            b.sat  = 4'((exp_cnt[i] > 15) ? 15 : exp_cnt[i]);
            q.push_back(b);
            exp_cnt[i] = 0;
        end
    endtask

    // One frame: a lead cycle with lv low, `lines` lines of `beats` beats,
    // then a frame-end cycle with lv high that must not be counted.
    task automatic frame(input int lines, input int beats,
                         input logic [19:0] pix, input bit push);
        fv = 1'b1; lv = 1'b0; pd = pix;
        tick();
        for (int l = 0; l < lines; l++) begin
            lv = 1'b1;
            repeat (beats) tick();
            lv = 1'b0;
            tick();
        end
        fv = 1'b0; lv = 1'b1;
        if (push) push_frame();
        tick();
        lv = 1'b0;
    endtask

    task automatic drain();
        bit done;
        for (int k = 0; k < 400; k++) begin
            if (q.size() == 0 && !hist_valid) break;
            tick();
        end
        done = (q.size() == 0) && !hist_valid;
        check("drain_done", {31'b0, done}, 32'd1);
    endtask

    // Monitor: compare every transferred beat against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (drop) drop_seen++;
            if (hist_valid && ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    beat_t b;
                    b = q.pop_front();
                    check("beat_bin",   {26'b0, hist_bin},  {26'b0, b.bin});
                    check("beat_data",  {8'b0, hist_data},  {8'b0, b.data});
                    check("beat_last",  {31'b0, hist_last}, {31'b0, b.last});
                    check("sat_valid",  {31'b0, s_valid},   32'd1);
                    check("sat_bin",    {26'b0, s_bin},     {26'b0, b.bin});
                    check("sat_data",   {28'b0, s_data},    {28'b0, b.sat});
                    check("sat_last",   {31'b0, s_last},    {31'b0, b.last});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < 64; i++) exp_cnt[i] = 0;
        rst_n = 1'b0; fv = 1'b0; lv = 1'b0; pd = '0;
        enable = 1'b0; ready = 1'b1;

        // Reset state
        #2;
        check("rst_valid", {31'b0, hist_valid}, 32'd0);
        check("rst_last",  {31'b0, hist_last},  32'd0);
        check("rst_bin",   {26'b0, hist_bin},   32'd0);
        check("rst_data",  {8'b0, hist_data},   32'd0);
        check("rst_fcnt",  {16'b0, frame_cnt},  32'd0);
        check("rst_drop",  {31'b0, drop},       32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("idle_valid", {31'b0, hist_valid}, 32'd0);
        check("idle_data",  {8'b0, hist_data},   32'd0);
        check("idle_fcnt",  {16'b0, frame_cnt},  32'd0);
        check("idle_drop",  {31'b0, drop},       32'd0);

        // Disabled frame: no capture, no dump, no drop
        frame(1, 4, {10'h3FF, 10'h000}, 1'b0);
        repeat (10) tick();
        check("disabled_fcnt", {16'b0, frame_cnt}, 32'd0);
        check("disabled_drop", drop_seen, 32'd0);

        // 2 lines x 4 beats of {3FF,000}: bin0=8, bin63=8
        enable = 1'b1;
        exp_cnt[0] = 8; exp_cnt[63] = 8;
        frame(2, 4, {10'h3FF, 10'h000}, 1'b1);
        drain();
        check("fcnt_1", {16'b0, frame_cnt}, 32'd1);

        // lv without fv ignored; 5 beats of {015,010}: bin1=10
        fv = 1'b0; lv = 1'b1; pd = {10'h015, 10'h010};
        repeat (2) tick();
        lv = 1'b0;
        exp_cnt[1] = 10;
        frame(1, 5, {10'h015, 10'h010}, 1'b1);
        drain();
        check("fcnt_2", {16'b0, frame_cnt}, 32'd2);

        // Back-pressure at bin 10, then an identical frame
        for (int f = 0; f < 2; f++) begin
            exp_cnt[10] = 6;
            frame(1, 3, {10'h0A0, 10'h0A5}, 1'b1);
            if (f == 0) begin
                found = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    if (hist_valid && hist_bin == 6'd10) begin
                        ready = 1'b0;
                        found = 1'b1;
                        break;
                    end
                    tick();
                end
                check("stall_reach", {31'b0, found}, 32'd1);
                repeat (5) begin
                    tick();
                    check("stall_valid", {31'b0, hist_valid}, 32'd1);
                    check("stall_bin",   {26'b0, hist_bin},   32'd10);
                    check("stall_data",  {8'b0, hist_data},   32'd6);
                end
                ready = 1'b1;
            end
            drain();
        end
        check("fcnt_4", {16'b0, frame_cnt}, 32'd4);

        // Frame start during DUMP: one drop pulse, nothing counted
        drop_seen = 0;
        exp_cnt[31] = 4; exp_cnt[32] = 4;
        frame(1, 4, {10'h200, 10'h1F0}, 1'b1);
        fv = 1'b1; lv = 1'b0; pd = {10'h3FF, 10'h000};
        tick();
        lv = 1'b1;
        drain();
        repeat (5) tick();
        fv = 1'b0; lv = 1'b0;
        repeat (3) tick();
        check("drop_pulses", drop_seen, 32'd1);
        check("fcnt_5",      {16'b0, frame_cnt}, 32'd5);
        exp_cnt[31] = 4; exp_cnt[32] = 4;
        frame(1, 4, {10'h200, 10'h1F0}, 1'b1);
        drain();
        check("fcnt_6", {16'b0, frame_cnt}, 32'd6);

        // 40 increments into bin 5: 40 at 24 bits, 15 at 4 bits
        exp_cnt[5] = 40;
        frame(1, 20, {10'h050, 10'h05F}, 1'b1);
        drain();
        check("fcnt_7",     {16'b0, frame_cnt}, 32'd7);
        check("sat_fcnt_7", {16'b0, s_fc},      32'd7);

        // Reset mid-ACCUM discards the partial frame
        fv = 1'b1; lv = 1'b0; pd = {10'h070, 10'h070};
        tick();
        lv = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0; fv = 1'b0; lv = 1'b0;
        #1;
        check("midrst_valid", {31'b0, hist_valid}, 32'd0);
        check("midrst_fcnt",  {16'b0, frame_cnt},  32'd0);
        check("midrst_sfcnt", {16'b0, s_fc},       32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        exp_cnt[2] = 6;
        frame(1, 3, {10'h020, 10'h02F}, 1'b1);
        drain();
        check("post_rst_fcnt", {16'b0, frame_cnt}, 32'd1);

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
